regfile_seq_ctrl: RTL and testbench

- Moore-style instruction sequencer for the 8x16 register-file datapath (regfile, shifter, ALU, A/B/C pipeline registers, status register).
- Captures one 16-bit instruction on a start strobe and drives the register file and datapath controls through a fixed multi-cycle sequence per instruction class.
- Reports idle/ready to the instruction source.
- Sits between the instruction source (switches/bench) and the datapath top.

---
 rtl/regfile_ctrl_pkg.sv | 30 +++
 rtl/regfile_seq_ctrl_instr_fields.sv | 26 ++
 rtl/regfile_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_regfile_seq_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and encodings for the register-file instruction sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_REG,
    S_WR_IMM
  } state_e;

  // Opcode classes (IR[15:13])
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Sub-op encodings (IR[12:11])
  localparam logic [1:0] OP_IMM    = 2'b10;  // under OPC_MOV
  localparam logic [1:0] OP_MOVREG = 2'b00;  // under OPC_MOV
  localparam logic [1:0] OP_CMP    = 2'b01;  // under OPC_ALU
  localparam logic [1:0] OP_MVN    = 2'b11;  // under OPC_ALU

  // Writeback source select
  localparam logic VSEL_C   = 1'b0;
  localparam logic VSEL_IMM = 1'b1;

endpackage

// File: rtl/regfile_seq_ctrl_instr_fields.sv
// Splits the instruction register into its fields and sign-extends imm8.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the IR continuously.
// Ports: ir (16b instruction) -> opcode, op, rn, rd, sh, rm, sximm8 (DATA_W).
module instr_fields #(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       ir,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [1:0]        sh,
  output logic [2:0]        rm,
  output logic [DATA_W-1:0] sximm8
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Moore sequencer: captures an instruction on s and steps the regfile/datapath controls.
// Latency: 2 busy cycles (MOV imm), 4 (CMP, MOV reg, MVN), 5 (ADD, AND) before w returns.
// Backpressure: w=1 only in WAIT; s outside WAIT is dropped, never queued.
// Ports: clk, rst_n, s, in_instr in; w, err, readnum, writenum, write, vsel,
//        loada/b/c/s, asel, bsel, shift, aluop, sximm8 out (all decoded from state + IR).
module regfile_seq_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s,
  input  logic [15:0]       in_instr,
  output logic              w,
  output logic              err,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        aluop,
  output logic [DATA_W-1:0] sximm8
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  instr_fields #(.DATA_W(DATA_W)) u_fields (
    .ir     (ir_q),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8)
  );

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, legal;

  assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_IMM);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOVREG);
  assign is_alu     = (opcode == OPC_ALU);
  assign is_cmp     = is_alu && (op == OP_CMP);
  assign is_mvn     = is_alu && (op == OP_MVN);
  assign legal      = is_mov_imm || is_mov_reg || is_alu;

  // Next-state and IR capture; IR only loads on acceptance so in_instr
  // may change freely while a sequence is in flight.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          ir_d    = in_instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_mov_imm)               state_d = S_WR_IMM;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;  // single-operand: skip A
        else if (is_alu)              state_d = S_GET_A;
        else                          state_d = S_WAIT;    // illegal: err pulses this cycle
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      S_EXEC:   state_d = is_cmp ? S_WAIT : S_WR_REG;      // CMP only updates status
      S_WR_REG: state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs depend on state_q (and IR) only, so an async reset drops
  // write immediately and no partial writeback can occur.
  always_comb begin
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    aluop    = 2'b00;
    case (state_q)
      S_WAIT:   w = 1'b1;
      S_DECODE: err = !legal;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = sh;
        // MOV reg is computed as 0 + shifted B
        aluop = is_mov_reg ? 2'b00 : op;
        asel  = is_mov_reg || is_mvn;
        if (is_cmp) loads = 1'b1;
        else        loadc = 1'b1;
      end
      S_WR_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
      end
      S_WR_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Scoreboard bench for regfile_seq_ctrl: per-cycle expected control vectors are
// queued as instructions are scheduled and compared on each falling clock edge.
// Each queue entry also carries the stimulus to apply after it is checked.
module tb_regfile_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s = 1'b0;
  logic [15:0] in_instr = 16'h0000;

  logic        w, err, write, vsel, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, aluop;
  logic [15:0] sximm8;

  regfile_seq_ctrl #(.DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s),
    .in_instr (in_instr),
    .w        (w),
    .err      (err),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .aluop    (aluop),
    .sximm8   (sximm8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic       err;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  // smode: 0 = drive s low, 1 = random s, 2 = hold s high (after this sample)
  typedef struct {
    ctrl_t       c;
    logic [15:0] sx;
    logic        go;
    logic [15:0] nxt;
    logic [1:0]  smode;
    string       tag;
  } exp_t;

  ctrl_t       act;
  exp_t        sb[$];
  logic [15:0] last_ir;
  int          n_checks = 0;
  int          n_fail   = 0;

  assign act = {w, err, readnum, writenum, write, vsel, loada, loadb,
                loadc, loads, asel, bsel, shift, aluop};

  function automatic logic [15:0] sx8(input logic [15:0] i);
    return {{8{i[7]}}, i[7:0]};
  endfunction

  // WAIT-cycle expectation; go=1 launches nxt right after this sample.
  task automatic push_wait(input logic go, input logic [15:0] nxt);
    exp_t e;
    e.c       = '0;
    e.c.w     = 1'b1;
    e.sx      = sx8(last_ir);
    e.go      = go;
    e.nxt     = nxt;
    e.smode   = 2'd0;
    e.tag     = go ? "wait/launch" : "wait";
    sb.push_back(e);
  endtask

  // Busy-cycle expectations for one instruction, written from the ISA table.
  task automatic push_busy(input logic [15:0] instr, input logic [1:0] smode, input string tag);
    exp_t       e;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic       mov_imm, mov_reg, alu, cmp, mvn;
    opc = instr[15:13]; op = instr[12:11]; rn = instr[10:8];
    rd  = instr[7:5];   sh = instr[4:3];   rm = instr[2:0];
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    alu     = (opc == 3'b101);
    cmp     = alu && (op == 2'b01);
    mvn     = alu && (op == 2'b11);
    last_ir = instr;
    e.sx = sx8(instr); e.go = 1'b0; e.nxt = '0; e.smode = smode;

    e.c = '0; e.c.err = !(mov_imm || mov_reg || alu);
    e.tag = {tag, "/decode"}; sb.push_back(e);
    if (!(mov_imm || mov_reg || alu)) return;
    if (mov_imm) begin
      e.c = '0; e.c.writenum = rn; e.c.vsel = 1'b1; e.c.write = 1'b1;
      e.tag = {tag, "/wr_imm"}; sb.push_back(e);
      return;
    end
    if (alu && !mvn) begin
      e.c = '0; e.c.readnum = rn; e.c.loada = 1'b1;
      e.tag = {tag, "/get_a"}; sb.push_back(e);
    end
    e.c = '0; e.c.readnum = rm; e.c.loadb = 1'b1;
    e.tag = {tag, "/get_b"}; sb.push_back(e);
    e.c = '0; e.c.shift = sh; e.c.aluop = mov_reg ? 2'b00 : op;
    e.c.asel = mov_reg || mvn;
    if (cmp) e.c.loads = 1'b1; else e.c.loadc = 1'b1;
    e.tag = {tag, "/exec"}; sb.push_back(e);
    if (!cmp) begin
      e.c = '0; e.c.writenum = rd; e.c.write = 1'b1;
      e.tag = {tag, "/wr_reg"}; sb.push_back(e);
    end
  endtask

  // Stimulus carried by an entry, applied right after it has been checked.
  task automatic apply_stim(input exp_t e);
    if (e.go) begin
      s = 1'b1; in_instr = e.nxt;
    end else begin
      case (e.smode)
        2'd1:    s = 1'($urandom_range(0, 1));
        2'd2:    s = 1'b1;
        default: s = 1'b0;
      endcase
      in_instr = 16'($urandom);
    end
  endtask

  task automatic test_reset;
    ctrl_t idle;
    idle = '0; idle.w = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (act !== idle) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h want %h", act, idle);
    end
    n_checks++;
    if (sximm8 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_sximm8: got %h want 0000", sximm8);
    end
    rst_n = 1'b1;
    last_ir = 16'h0000;
  endtask

  task automatic test_mov_imm;
    exp_t e;
    push_wait(1'b1, 16'hD3FE);
    push_busy(16'hD3FE, 2'd0, "mov_imm");
    push_wait(1'b0, 16'h0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (act !== e.c || sximm8 !== e.sx) begin
        n_fail++;
        $display("FAIL mov_imm %s: got ctrl=%h sx=%h want ctrl=%h sx=%h", e.tag, act, sximm8, e.c, e.sx);
      end
      apply_stim(e);
    end
  endtask

  // ADD, CMP (LSL), AND (Rn=Rd=Rm), MVN, with random s/in_instr while busy
  task automatic test_alu_ops;
    exp_t        e;
    logic [15:0] prog [4];
    prog[0] = 16'hA140; prog[1] = 16'hA90A; prog[2] = 16'hB242; prog[3] = 16'hB876;
    for (int i = 0; i < 4; i++) begin
      push_wait(1'b0, 16'h0000);
      push_wait(1'b1, prog[i]);
      push_busy(prog[i], 2'd1, "alu");
    end
    push_wait(1'b0, 16'h0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (act !== e.c || sximm8 !== e.sx) begin
        n_fail++;
        $display("FAIL alu_ops %s: got ctrl=%h sx=%h want ctrl=%h sx=%h", e.tag, act, sximm8, e.c, e.sx);
      end
      apply_stim(e);
    end
  endtask

  task automatic test_mov_reg;
    exp_t e;
    push_wait(1'b1, 16'hC085);
    push_busy(16'hC085, 2'd1, "mov_reg");
    push_wait(1'b0, 16'h0000);
    push_wait(1'b1, 16'hC0FA);
    push_busy(16'hC0FA, 2'd0, "mov_reg_sh");
    push_wait(1'b0, 16'h0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (act !== e.c || sximm8 !== e.sx) begin
        n_fail++;
        $display("FAIL mov_reg %s: got ctrl=%h sx=%h want ctrl=%h sx=%h", e.tag, act, sximm8, e.c, e.sx);
      end
      apply_stim(e);
    end
  endtask

  task automatic test_illegal;
    exp_t        e;
    logic [15:0] prog [4];
    prog[0] = 16'h0000; prog[1] = 16'hC800; prog[2] = 16'hD800; prog[3] = 16'hE000;
    for (int i = 0; i < 4; i++) begin
      push_wait(1'b1, prog[i]);
      push_busy(prog[i], 2'd0, "illegal");
      push_wait(1'b0, 16'h0000);
    end
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (act !== e.c || sximm8 !== e.sx) begin
        n_fail++;
        $display("FAIL illegal %s: got ctrl=%h sx=%h want ctrl=%h sx=%h", e.tag, act, sximm8, e.c, e.sx);
      end
      apply_stim(e);
    end
  endtask

  // s held high throughout: each WAIT lasts exactly one cycle
  task automatic test_back_to_back;
    exp_t e;
    push_wait(1'b1, 16'hD3FE);
    push_busy(16'hD3FE, 2'd2, "b2b_imm");
    push_wait(1'b1, 16'hA140);
    push_busy(16'hA140, 2'd2, "b2b_add");
    push_wait(1'b1, 16'hC085);
    push_busy(16'hC085, 2'd2, "b2b_mov");
    push_wait(1'b0, 16'h0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (act !== e.c || sximm8 !== e.sx) begin
        n_fail++;
        $display("FAIL back_to_back %s: got ctrl=%h sx=%h want ctrl=%h sx=%h", e.tag, act, sximm8, e.c, e.sx);
      end
      apply_stim(e);
    end
  endtask

  // Reset during WR_REG of an ADD, then s held across release
  task automatic test_reset_mid;
    exp_t  e;
    ctrl_t idle;
    push_wait(1'b0, 16'h0000);
    push_wait(1'b1, 16'hA140);
    push_busy(16'hA140, 2'd0, "rst_add");
    // WAIT, WAIT/launch, DECODE, GET_A, GET_B, EXEC, WR_REG
    repeat (7) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (act !== e.c || sximm8 !== e.sx) begin
        n_fail++;
        $display("FAIL reset_mid %s: got ctrl=%h sx=%h want ctrl=%h sx=%h", e.tag, act, sximm8, e.c, e.sx);
      end
      apply_stim(e);
    end
    sb.delete();
    #1 rst_n = 1'b0;
    #1;
    idle = '0; idle.w = 1'b1;
    n_checks++;
    if (act !== idle || sximm8 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid async: got ctrl=%h sx=%h want ctrl=%h sx=0000", act, sximm8, idle);
    end
    s = 1'b1;
    in_instr = 16'hD3FE;
    #1 rst_n = 1'b1;
    last_ir = 16'h0000;
    push_busy(16'hD3FE, 2'd0, "post_rst");
    push_wait(1'b0, 16'h0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (act !== e.c || sximm8 !== e.sx) begin
        n_fail++;
        $display("FAIL reset_mid %s: got ctrl=%h sx=%h want ctrl=%h sx=%h", e.tag, act, sximm8, e.c, e.sx);
      end
      apply_stim(e);
    end
  endtask

  initial begin
    last_ir = 16'h0000;
    test_reset();
    test_mov_imm();
    test_alu_ops();
    test_mov_reg();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
